mem_arbiter: RTL and testbench

//  Shares the single RAM port between instruction fetch (I) and data access (D) requesters.

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake states and the memory arbiter FSM encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data access, one transaction at a time.
// Data wins contention; a starvation counter forces a fetch grant; stalled grants abort on ERROR/timeout.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        abort
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state, state_n;
    ramstate_t        rs;
    logic [SW-1:0]    starve_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             d_req, stall_abort;

    assign rs          = ramstate_t'(ramstate);
    assign d_req       = dREN | dWEN;
    assign stall_abort = (rs == ERROR) || (tmo_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_n;

            if (state == IDLE)
                tmo_cnt <= '0;
            else if (rs != ACCESS)
                tmo_cnt <= tmo_cnt + CNT_W'(1);

            if (!iREN || ihit)
                starve_cnt <= '0;
            else if (dhit && starve_cnt != SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // A withdrawn request ends the grant silently, ahead of completion and abort.
    always_comb begin
        state_n  = state;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        abort    = 1'b0;
        unique case (state)
            IDLE: begin
                if (iREN && starve_cnt == SW'(STARVE_LIMIT))
                    state_n = IGNT;
                else if (d_req)
                    state_n = DGNT;
                else if (iREN)
                    state_n = IGNT;
            end
            DGNT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!d_req) begin
                    state_n = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN & ~dWEN;
                    if (rs == ACCESS) begin
                        dhit    = 1'b1;
                        state_n = IDLE;
                    end else if (stall_abort) begin
                        abort   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            IGNT: begin
                ramaddr = iaddr;
                if (!iREN) begin
                    state_n = IDLE;
                end else begin
                    ramREN = 1'b1;
                    if (rs == ACCESS) begin
                        ihit    = 1'b1;
                        state_n = IDLE;
                    end else if (stall_abort) begin
                        abort   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign iload = ihit ? ramload : '0;
    assign dload = dhit ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hand-computed expectations, inputs driven 1ns after the
// rising edge and combinational outputs checked 1ns later within the same cycle.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        ramREN, ramWEN, ihit, dhit, abort;
    logic [31:0] ramaddr, ramstore, iload, dload;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64), .CNT_W(7)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ramstate(ramstate), .ramload(ramload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload), .abort(abort)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        #2;
        check("rst_ramREN", {31'b0, ramREN}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_hits_abort", {29'b0, ihit, dhit, abort}, 32'd0);
        step(); step();
        RST = 1'b0;

        // I fetch: IDLE cycle then ACCESS completes
        iREN = 1'b1; iaddr = 32'h40; #1;
        check("i_idle_ren", {31'b0, ramREN}, 32'd0);
        step(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
        check("i_ren", {31'b0, ramREN}, 32'd1);
        check("i_addr", ramaddr, 32'h40);
        check("i_hit", {31'b0, ihit}, 32'd1);
        check("i_load", iload, 32'hDEADBEEF);
        step(); iREN = 1'b0; ramstate = FREE; #1;
        check("i_after_hit", {30'b0, ihit, ramREN}, 32'd0);

        // Contention: D (write, with dREN also set) wins, then I is served
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'h5; #1;
        step(); ramstate = BUSY; #1;
        check("c_wen_ren", {30'b0, ramWEN, ramREN}, 32'd2);
        check("c_addr", ramaddr, 32'h100);
        check("c_store", ramstore, 32'h5);
        check("c_busy_nohit", {31'b0, dhit}, 32'd0);
        step(); ramstate = ACCESS; #1;
        check("c_dhit", {31'b0, dhit}, 32'd1);
        step(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE; #1;
        check("c_idle_gap", {30'b0, ramWEN, ramREN}, 32'd0);
        step(); ramstate = ACCESS; ramload = 32'h1111; #1;
        check("c_i_addr", ramaddr, 32'h80);
        check("c_ihit", {31'b0, ihit}, 32'd1);
        step(); iREN = 1'b0; ramstate = FREE; #1;

        // Starvation: 4 D grants, then a forced I grant
        iREN = 1'b1; iaddr = 32'hC0; dREN = 1'b1; daddr = 32'h200; #1;
        for (int k = 0; k < 4; k++) begin
            step(); ramstate = ACCESS; ramload = 32'(k); #1;
            check("s_daddr", ramaddr, 32'h200);
            check("s_dhit", {31'b0, dhit}, 32'd1);
            check("s_dload", dload, 32'(k));
            step(); ramstate = FREE; #1;
        end
        check("s_cnt_sat", 32'(dut.starve_cnt), 32'd4);
        step(); ramstate = ACCESS; ramload = 32'hABCD; #1;
        check("s_forced_iaddr", ramaddr, 32'hC0);
        check("s_forced_ihit", {30'b0, ihit, dhit}, 32'd2);
        step(); iREN = 1'b0; dREN = 1'b0; ramstate = FREE; #1;
        check("s_cnt_clr", 32'(dut.starve_cnt), 32'd0);

        // Withdrawal while BUSY
        dREN = 1'b1; daddr = 32'h300; #1;
        step(); ramstate = BUSY; #1;
        check("w_ren", {31'b0, ramREN}, 32'd1);
        step(); dREN = 1'b0; #1;
        check("w_drop", {29'b0, ramREN, dhit, abort}, 32'd0);
        step(); dREN = 1'b1; ramstate = ACCESS; #1;
        check("w_idle_next", {30'b0, ramREN, dhit}, 32'd0);
        step(); #1;
        check("w_regrant_hit", {31'b0, dhit}, 32'd1);
        step(); dREN = 1'b0; ramstate = FREE; #1;

        // Timeout: BUSY for the whole grant, abort on the 64th grant cycle
        dREN = 1'b1; daddr = 32'h400; #1;
        for (int g = 1; g <= 64; g++) begin
            step(); ramstate = BUSY; #1;
            if (g == 1 || g == 63) check("t_no_abort", {31'b0, abort}, 32'd0);
            if (g == 64) check("t_abort", {30'b0, abort, dhit}, 32'd2);
        end
        step(); dREN = 1'b0; ramstate = FREE; #1;
        check("t_idle_after", {30'b0, ramREN, abort}, 32'd0);

        // ACCESS on the timeout cycle completes instead of aborting
        dREN = 1'b1; #1;
        for (int g = 1; g <= 64; g++) begin
            step(); ramstate = (g == 64) ? ACCESS : BUSY; #1;
        end
        check("t_access_wins", {30'b0, abort, dhit}, 32'd1);
        step(); dREN = 1'b0; ramstate = FREE; #1;

        // ERROR during an I grant
        iREN = 1'b1; iaddr = 32'h44; #1;
        step(); ramstate = BUSY; #1;
        check("e_busy", {31'b0, abort}, 32'd0);
        step(); ramstate = ERROR; #1;
        check("e_abort", {30'b0, abort, ihit}, 32'd2);
        step(); ramstate = FREE; #1;
        check("e_idle_after", {30'b0, ramREN, abort}, 32'd0);
        step(); iREN = 1'b0; #1;

        // Reset in the middle of an I grant
        step(); iREN = 1'b1; iaddr = 32'h48; #1;
        step(); ramstate = BUSY; #1;
        check("r_pre_ren", {31'b0, ramREN}, 32'd1);
        RST = 1'b1; ramstate = ACCESS; #1;
        check("r_async_drop", {30'b0, ramREN, ihit}, 32'd0);
        check("r_async_addr", ramaddr, 32'd0);
        step(); RST = 1'b0; ramstate = FREE; #1;
        check("r_idle_after", {31'b0, ramREN}, 32'd0);
        step(); ramstate = ACCESS; ramload = 32'h1234; #1;
        check("r_ihit", {31'b0, ihit}, 32'd1);
        check("r_iload", iload, 32'h1234);
        step(); iREN = 1'b0; ramstate = FREE; #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
